mda_sequencer: RTL and testbench

MDA_SEQUENCER -- requirements
Module: mda_sequencer

---
 rtl/mda_pkg.sv | 24 ++
 rtl/mda_cpu_arb.sv | 63 ++++++
 rtl/mda_sequencer.sv | 62 ++++++
 tb/tb_mda_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mda_pkg.sv
// Shared constants, arbiter state type and phase helper for the MDA character-cell sequencer.
package mda_pkg;

  localparam int unsigned SEQ_W         = 5;
  localparam int unsigned CELL_LEN      = 18;
  localparam int unsigned PH_CHAR       = 5;
  localparam int unsigned PH_ATT        = 9;
  localparam int unsigned PH_ROW        = 17;
  localparam int unsigned VRAM_RD_FIRST = 2;
  localparam int unsigned VRAM_RD_LAST  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACCESS  = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Next cell phase, wrapping at the end of the 9-dot cell.
  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
    return (s == SEQ_W'(CELL_LEN - 1)) ? '0 : s + SEQ_W'(1);
  endfunction

endpackage

// File: rtl/mda_cpu_arb.sv
// CPU VRAM slot arbiter: grants one fixed-length slot per request inside the cell.
// Optional feature macro: MDA_CPU_WAIT_EN (drives cpu_wait while the CPU is held off).
module mda_cpu_arb
  import mda_pkg::*;
#(
  parameter int unsigned SLOT_START = 10,
  parameter int unsigned SLOT_LEN   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic [4:0] seq_next,
  output logic       cpu_sel,
  output logic       cpu_ack,
  output logic       cpu_wait
);

  localparam logic [SEQ_W-1:0] SLOT_FIRST = SEQ_W'(SLOT_START);
  localparam logic [SEQ_W-1:0] SLOT_LAST  = SEQ_W'(SLOT_START + SLOT_LEN - 1);
  localparam logic [SEQ_W-1:0] SLOT_END   = SEQ_W'(SLOT_START + SLOT_LEN);

  arb_state_e state, state_next;
  logic       ack_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cpu_sel <= 1'b0;
      cpu_ack <= 1'b0;
    end else begin
      state   <= state_next;
      cpu_sel <= (state_next == ACCESS);
      cpu_ack <= ack_next;
    end
  end

  // Transitions are decided against the phase the sequencer is about to enter.
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    unique case (state)
      IDLE:    if (cpu_req) state_next = PENDING;
      PENDING: begin
        if (!cpu_req)                    state_next = IDLE;
        else if (seq_next == SLOT_FIRST) state_next = ACCESS;
      end
      ACCESS:  if (seq_next == SLOT_END) state_next = DONE;
      DONE:    if (!cpu_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ack_next = (state_next == ACCESS) && (seq_next == SLOT_LAST);
  end

`ifdef MDA_CPU_WAIT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_wait <= 1'b0;
    else          cpu_wait <= (state_next == PENDING) || ((state_next == ACCESS) && !ack_next);
  end
`else
  assign cpu_wait = 1'b0;
`endif

endmodule

// File: rtl/mda_sequencer.sv
// MDA character-cell sequencer: 18-clock phase counter, display VRAM strobes and CPU slot arbiter.
// Optional feature macro: MDA_CPU_WAIT_EN (ISA wait request from the arbiter).
module mda_sequencer
  import mda_pkg::*;
#(
  parameter int unsigned CPU_SLOT_START = 10,
  parameter int unsigned CPU_SLOT_LEN   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  output logic [4:0] clk_seq,
  output logic       vram_read,
  output logic       vram_read_char,
  output logic       vram_read_att,
  output logic       charrom_read,
  output logic       disp_pipeline,
  output logic       crtc_clk,
  output logic       cpu_sel,
  output logic       cpu_ack,
  output logic       cpu_wait
);

  logic [SEQ_W-1:0] seq_next;

  assign seq_next = seq_inc(clk_seq);

  // Strobes decode the upcoming phase so each output lines up with clk_seq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_seq        <= '0;
      vram_read      <= 1'b0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
      crtc_clk       <= 1'b0;
    end else begin
      clk_seq        <= seq_next;
      vram_read      <= (seq_next >= SEQ_W'(VRAM_RD_FIRST)) && (seq_next <= SEQ_W'(VRAM_RD_LAST));
      vram_read_char <= (seq_next == SEQ_W'(PH_CHAR));
      vram_read_att  <= (seq_next == SEQ_W'(PH_ATT));
      charrom_read   <= (seq_next == SEQ_W'(PH_ROW));
      disp_pipeline  <= (seq_next == SEQ_W'(PH_ROW));
      crtc_clk       <= (seq_next == SEQ_W'(PH_ROW));
    end
  end

  mda_cpu_arb #(
    .SLOT_START (CPU_SLOT_START),
    .SLOT_LEN   (CPU_SLOT_LEN)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_req  (cpu_req),
    .seq_next (seq_next),
    .cpu_sel  (cpu_sel),
    .cpu_ack  (cpu_ack),
    .cpu_wait (cpu_wait)
  );

endmodule

// File: tb/tb_mda_sequencer.sv
// Testbench for mda_sequencer: time-based reference model of phases and CPU slot grants.
module tb_mda_sequencer;

  localparam int CELL  = 18;
  localparam int START = 10;
  localparam int LEN   = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic [4:0] clk_seq;
  logic       vram_read, vram_read_char, vram_read_att;
  logic       charrom_read, disp_pipeline, crtc_clk;
  logic       cpu_sel, cpu_ack, cpu_wait;

  mda_sequencer #(.CPU_SLOT_START(START), .CPU_SLOT_LEN(LEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .clk_seq        (clk_seq),
    .vram_read      (vram_read),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .crtc_clk       (crtc_clk),
    .cpu_sel        (cpu_sel),
    .cpu_ack        (cpu_ack),
    .cpu_wait       (cpu_wait)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: t counts clocks since reset release; a request owns one grant time
  // (first later clock whose phase is START) until it is cancelled or retired.
  longint t = 0;
  longint grant_t = 0;
  bit     have_grant = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int d;
    if (!reset_n) begin
      t = 0;
      have_grant = 1'b0;
      return;
    end
    t++;
    if (have_grant) begin
      if (t <= grant_t) begin
        if (!cpu_req) have_grant = 1'b0;
      end else if (t > grant_t + LEN && !cpu_req) begin
        have_grant = 1'b0;
      end
    end else if (cpu_req) begin
      d = (START - int'(t % CELL) + CELL) % CELL;
      if (d == 0) d = CELL;
      grant_t    = t + d;
      have_grant = 1'b1;
    end
  endtask

  task automatic compare_all();
    int seq;
    bit e_sel, e_ack, e_wait;
    seq    = int'(t % CELL);
    e_sel  = have_grant && (t >= grant_t) && (t <= grant_t + LEN - 1);
    e_ack  = have_grant && (t == grant_t + LEN - 1);
`ifdef MDA_CPU_WAIT_EN
    e_wait = have_grant && (t < grant_t + LEN - 1);
`else
    e_wait = 1'b0;
`endif
    check("clk_seq",        32'(clk_seq),        32'(seq));
    check("vram_read",      32'(vram_read),      32'(seq >= 2 && seq <= 9));
    check("vram_read_char", 32'(vram_read_char), 32'(seq == 5));
    check("vram_read_att",  32'(vram_read_att),  32'(seq == 9));
    check("charrom_read",   32'(charrom_read),   32'(seq == 17));
    check("disp_pipeline",  32'(disp_pipeline),  32'(seq == 17));
    check("crtc_clk",       32'(crtc_clk),       32'(seq == 17));
    check("cpu_sel",        32'(cpu_sel),        32'(e_sel));
    check("cpu_ack",        32'(cpu_ack),        32'(e_ack));
    check("cpu_wait",       32'(cpu_wait),       32'(e_wait));
    check("bus_excl",       32'(cpu_sel & vram_read), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic seek_seq(input int v);
    for (int i = 0; i <= CELL; i++) begin
      if (int'(t % CELL) == v) return;
      tick();
    end
  endtask

  // Request must be acknowledged within one full cell plus the slot length.
  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < CELL + LEN; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  initial begin
    int cnt;

    repeat (3) tick();
    reset_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vram_read_char === 1'b1) cnt++;
    end
    check("char_strobes_40", 32'(cnt), 32'(2));

    seek_seq(3);
    cpu_req = 1'b1;
    wait_ack("ack_req_at_3");
    cpu_req = 1'b0;
    repeat (4) tick();

    seek_seq(12);
    cpu_req = 1'b1;
    wait_ack("ack_req_at_12");
    cpu_req = 1'b0;
    repeat (4) tick();

    cpu_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_ack === 1'b1) cnt++;
    end
    check("held_req_acks", 32'(cnt), 32'(1));
    cpu_req = 1'b0;
    repeat (3) tick();
    cpu_req = 1'b1;
    wait_ack("ack_reraise");
    cpu_req = 1'b0;
    repeat (3) tick();

    seek_seq(0);
    cpu_req = 1'b1;
    wait_ack("ack_req_at_0");
    cpu_req = 1'b0;
    repeat (3) tick();

    // Random request toggling exercises drops in PENDING, ACCESS and DONE.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
      tick();
    end
    cpu_req = 1'b0;
    repeat (20) tick();

    // Reset landing in the middle of a CPU slot.
    seek_seq(0);
    cpu_req = 1'b1;
    seek_seq(12);
    check("slot_active_pre_rst", 32'(cpu_sel), 32'(1));
    reset_n = 1'b0;
    #1;
    model_step();
    compare_all();
    repeat (2) tick();
    cpu_req = 1'b0;
    reset_n = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
